// File: rtl/pipe_stage_reg_if.sv
// ============================================================================
// Module      : pipe_stage_reg_if
// Description : Upstream/downstream handshake, hazard controls and status
//               signals of a two-entry pipeline stage register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pipe_stage_reg_if #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [CTRL_W-1:0] in_ctrl;
    logic [DATA_W-1:0] in_data;
    logic              stall;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [CTRL_W-1:0] out_ctrl;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        occ;
    logic [CNT_W-1:0]  bubble_cnt;

    // Stage side
    modport slave (
        input  in_valid, in_ctrl, in_data, stall, flush, out_ready,
        output in_ready, out_valid, out_ctrl, out_data, occ, bubble_cnt
    );

    // Surrounding pipeline / hazard unit side
    modport master (
        output in_valid, in_ctrl, in_data, stall, flush, out_ready,
        input  in_ready, out_valid, out_ctrl, out_data, occ, bubble_cnt
    );
endinterface

`default_nettype wire

// File: rtl/pipe_stage_reg.sv
// ============================================================================
// Module      : pipe_stage_reg
// Description : Two-entry (MAIN + SKID) pipeline stage register with stall,
//               flush, nop-forcing of bubbles and a saturating bubble counter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pipe_stage_reg #(
    parameter int DATA_W = 32,
    parameter int CTRL_W = 12,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             rst,
    pipe_stage_reg_if.slave  bus
);

    localparam logic [CNT_W-1:0] c_bubble_max = '1;
    localparam logic [CNT_W-1:0] c_bubble_one = {{(CNT_W-1){1'b0}}, 1'b1};

    logic              r_main_vld;
    logic [CTRL_W-1:0] r_main_ctrl;
    logic [DATA_W-1:0] r_main_data;
    logic              r_skid_vld;
    logic [CTRL_W-1:0] r_skid_ctrl;
    logic [DATA_W-1:0] r_skid_data;
    logic              r_in_ready;
    logic [CNT_W-1:0]  r_bubble;

    logic              w_push;
    logic              w_pop;
    logic              w_main_vld_nxt;
    logic [CTRL_W-1:0] w_main_ctrl_nxt;
    logic [DATA_W-1:0] w_main_data_nxt;
    logic              w_skid_vld_nxt;
    logic [CTRL_W-1:0] w_skid_ctrl_nxt;
    logic [DATA_W-1:0] w_skid_data_nxt;
    logic [CNT_W-1:0]  w_bubble_nxt;

    always_comb begin
        w_push          = bus.in_valid & r_in_ready;
        w_pop           = r_main_vld & bus.out_ready & ~bus.stall;
        w_main_vld_nxt  = r_main_vld;
        w_main_ctrl_nxt = r_main_ctrl;
        w_main_data_nxt = r_main_data;
        w_skid_vld_nxt  = r_skid_vld;
        w_skid_ctrl_nxt = r_skid_ctrl;
        w_skid_data_nxt = r_skid_data;

        // SKID can only be occupied while MAIN is, so an empty MAIN implies
        // an empty stage; in_ready low guarantees no push while SKID is full.
        if (bus.flush) begin
            w_main_vld_nxt = 1'b0;
            w_skid_vld_nxt = 1'b0;
        end else if (!r_main_vld) begin
            if (w_push) begin
                w_main_vld_nxt  = 1'b1;
                w_main_ctrl_nxt = bus.in_ctrl;
                w_main_data_nxt = bus.in_data;
            end
        end else if (w_pop) begin
            if (r_skid_vld) begin
                w_main_ctrl_nxt = r_skid_ctrl;
                w_main_data_nxt = r_skid_data;
                w_skid_vld_nxt  = 1'b0;
            end else if (w_push) begin
                w_main_ctrl_nxt = bus.in_ctrl;
                w_main_data_nxt = bus.in_data;
            end else begin
                w_main_vld_nxt  = 1'b0;
            end
        end else if (w_push) begin
            w_skid_vld_nxt  = 1'b1;
            w_skid_ctrl_nxt = bus.in_ctrl;
            w_skid_data_nxt = bus.in_data;
        end
    end

    always_comb begin
        w_bubble_nxt = r_bubble;
        if (!r_main_vld && (r_bubble != c_bubble_max)) begin
            w_bubble_nxt = r_bubble + c_bubble_one;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_main_vld  <= 1'b0;
            r_main_ctrl <= '0;
            r_main_data <= '0;
            r_skid_vld  <= 1'b0;
            r_skid_ctrl <= '0;
            r_skid_data <= '0;
            r_in_ready  <= 1'b1;
            r_bubble    <= '0;
        end else begin
            r_main_vld  <= w_main_vld_nxt;
            r_main_ctrl <= w_main_ctrl_nxt;
            r_main_data <= w_main_data_nxt;
            r_skid_vld  <= w_skid_vld_nxt;
            r_skid_ctrl <= w_skid_ctrl_nxt;
            r_skid_data <= w_skid_data_nxt;
            r_in_ready  <= ~w_skid_vld_nxt;
            r_bubble    <= w_bubble_nxt;
        end
    end

    // A bubble presents all-zero control so downstream treats it as a nop.
    assign bus.in_ready   = r_in_ready;
    assign bus.out_valid  = r_main_vld;
    assign bus.out_ctrl   = r_main_vld ? r_main_ctrl : '0;
    assign bus.out_data   = r_main_data;
    assign bus.occ        = {1'b0, r_main_vld} + {1'b0, r_skid_vld};
    assign bus.bubble_cnt = r_bubble;

endmodule

`default_nettype wire

// File: tb/tb_pipe_stage_reg.sv
// ============================================================================
// Module      : tb_pipe_stage_reg
// Description : Self-checking bench for pipe_stage_reg: FIFO-of-two reference
//               model with scoreboard monitor, directed and random stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pipe_stage_reg;

    localparam int c_data_w  = 32;
    localparam int c_ctrl_w  = 12;
    localparam int c_cnt_w   = 4;
    localparam int c_bub_max = (1 << c_cnt_w) - 1;

    typedef struct {
        logic [c_ctrl_w-1:0] c;
        logic [c_data_w-1:0] d;
    } beat_t;

    logic clk = 1'b0;
    logic rst = 1'b0;

    pipe_stage_reg_if #(.DATA_W(c_data_w), .CTRL_W(c_ctrl_w), .CNT_W(c_cnt_w)) bus ();

    pipe_stage_reg #(.DATA_W(c_data_w), .CTRL_W(c_ctrl_w), .CNT_W(c_cnt_w)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: the stage is an ordered queue of at most two beats.
    beat_t               mdl_q[$];
    int                  mdl_bub  = 0;
    logic [c_data_w-1:0] mdl_last = '0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                mdl_q.delete();
                mdl_bub  = 0;
                mdl_last = '0;
            end else begin
                bit    acc;
                bit    pop;
                beat_t b;
                acc = bus.in_valid && (mdl_q.size() < 2);
                pop = (mdl_q.size() > 0) && bus.out_ready && !bus.stall;
                if (mdl_q.size() == 0 && mdl_bub < c_bub_max) mdl_bub++;
                if (bus.flush) begin
                    mdl_q.delete();
                end else begin
                    if (pop) void'(mdl_q.pop_front());
                    if (acc) begin
                        b.c = bus.in_ctrl;
                        b.d = bus.in_data;
                        mdl_q.push_back(b);
                    end
                end
                if (mdl_q.size() > 0) mdl_last = mdl_q[0].d;
            end
        end
    end

    // Monitor: compare every observable output against the model mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            chk("out_valid", {63'd0, bus.out_valid}, {63'd0, mdl_q.size() > 0});
            chk("occ", {62'd0, bus.occ}, 64'(mdl_q.size()));
            chk("in_ready", {63'd0, bus.in_ready}, {63'd0, mdl_q.size() < 2});
            chk("bubble_cnt", {60'd0, bus.bubble_cnt}, 64'(mdl_bub));
            chk("out_data", {32'd0, bus.out_data}, {32'd0, mdl_last});
            if (mdl_q.size() > 0)
                chk("out_ctrl", {52'd0, bus.out_ctrl}, {52'd0, mdl_q[0].c});
            else
                chk("out_ctrl_nop", {52'd0, bus.out_ctrl}, 64'd0);
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic drv(input bit iv, input logic [c_ctrl_w-1:0] c, input logic [c_data_w-1:0] d,
                       input bit ordy, input bit st, input bit fl);
        bus.in_valid  = iv;
        bus.in_ctrl   = c;
        bus.in_data   = d;
        bus.out_ready = ordy;
        bus.stall     = st;
        bus.flush     = fl;
    endtask

    task automatic async_reset_pulse();
        #1 rst = 1'b1;
        #1;
        chk("rst_out_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("rst_occ", {62'd0, bus.occ}, 64'd0);
        chk("rst_out_ctrl", {52'd0, bus.out_ctrl}, 64'd0);
        chk("rst_out_data", {32'd0, bus.out_data}, 64'd0);
        chk("rst_bubble", {60'd0, bus.bubble_cnt}, 64'd0);
        chk("rst_in_ready", {63'd0, bus.in_ready}, 64'd1);
        rst = 1'b0;
    endtask

    initial begin
        drv(0, '0, '0, 1, 0, 0);
        #1 rst = 1'b1;
        step();
        step();
        rst = 1'b0;

        // Back-to-back flow-through, first push on the first edge after reset
        drv(1, 12'h0A1, 32'h11, 1, 0, 0);
        step();
        chk("ff_a_data", {32'd0, bus.out_data}, 64'h11);
        chk("ff_a_occ", {62'd0, bus.occ}, 64'd1);
        drv(1, 12'h0A2, 32'h22, 1, 0, 0);
        step();
        chk("ff_b_data", {32'd0, bus.out_data}, 64'h22);
        chk("ff_b_rdy", {63'd0, bus.in_ready}, 64'd1);
        drv(0, '0, '0, 1, 0, 0);
        step();

        // Backpressure: fill both entries, third beat refused, order kept
        drv(1, 12'h0B1, 32'h33, 0, 0, 0); step();
        drv(1, 12'h0B2, 32'h44, 0, 0, 0); step();
        chk("bp_occ2", {62'd0, bus.occ}, 64'd2);
        chk("bp_rdy0", {63'd0, bus.in_ready}, 64'd0);
        drv(1, 12'h0B3, 32'h55, 0, 0, 0); step();
        chk("bp_c_refused", {62'd0, bus.occ}, 64'd2);
        drv(1, 12'h0B3, 32'h55, 1, 0, 0); step();
        chk("bp_out_b", {32'd0, bus.out_data}, 64'h44);
        step();
        chk("bp_out_c", {32'd0, bus.out_data}, 64'h55);
        drv(0, '0, '0, 1, 0, 0); step();
        chk("bp_hold_data", {32'd0, bus.out_data}, 64'h55);

        // Stall with both entries full
        drv(1, 12'h0C1, 32'h66, 0, 0, 0); step();
        drv(1, 12'h0C2, 32'h77, 0, 0, 0); step();
        for (int i = 0; i < 3; i++) begin
            drv(0, '0, '0, 1, 1, 0); step();
            chk("stall_data", {32'd0, bus.out_data}, 64'h66);
            chk("stall_occ", {62'd0, bus.occ}, 64'd2);
        end
        drv(0, '0, '0, 1, 0, 0); step();
        chk("stall_pop_b", {32'd0, bus.out_data}, 64'h77);
        step();

        // Flush drops held beats and the same-cycle push
        drv(1, 12'h0D1, 32'h88, 0, 0, 0); step();
        drv(1, 12'h0D2, 32'h99, 0, 0, 0); step();
        drv(1, 12'h0D3, 32'hAA, 0, 0, 1); step();
        chk("flush_valid", {63'd0, bus.out_valid}, 64'd0);
        chk("flush_ctrl", {52'd0, bus.out_ctrl}, 64'd0);
        chk("flush_occ", {62'd0, bus.occ}, 64'd0);
        drv(0, '0, '0, 1, 0, 0); step();

        // Asynchronous reset between edges while full
        drv(1, 12'h0E1, 32'hBB, 0, 0, 0); step();
        drv(1, 12'h0E2, 32'hCC, 0, 0, 0); step();
        drv(0, '0, '0, 1, 0, 0);
        async_reset_pulse();

        // Idle: bubble counter saturates and holds
        for (int i = 0; i < 20; i++) step();
        chk("bubble_sat", {60'd0, bus.bubble_cnt}, 64'(c_bub_max));
        step(); step();
        chk("bubble_hold", {60'd0, bus.bubble_cnt}, 64'(c_bub_max));

        drv(1, 12'h0F1, 32'hDD, 1, 0, 0); step();
        chk("resume_data", {32'd0, bus.out_data}, 64'hDD);
        chk("resume_occ", {62'd0, bus.occ}, 64'd1);
        drv(0, '0, '0, 1, 0, 0); step();

        // Random traffic with occasional stall, flush and async reset
        for (int i = 0; i < 3000; i++) begin
            drv($urandom_range(0, 99) < 60, c_ctrl_w'($urandom), $urandom,
                $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 10,
                $urandom_range(0, 99) < 4);
            if ($urandom_range(0, 499) == 0) async_reset_pulse();
            step();
        end
        drv(0, '0, '0, 1, 0, 0);
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 Parameter DATA_W, default 32: width of the datapath payload, for example ALU result or read data.
REQ-002 Parameter CTRL_W, default 12: width of the control-bit bundle, for example mem_to_reg, reg_write and opcode flags.
REQ-003 Parameter CNT_W, default 16: width of the bubble counter.
REQ-004 Port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1: asynchronous active-high reset.
REQ-006 Port in_valid, input, 1: upstream stage presents a beat.
REQ-007 Port in_ready, output, 1: stage can accept a beat this cycle.
REQ-008 Port in_ctrl, input, CTRL_W: control bits of the incoming beat.
REQ-009 Port in_data, input, DATA_W: payload of the incoming beat.
REQ-010 Port stall, input, 1: hazard unit freezes the output entry.
REQ-011 Port flush, input, 1: hazard unit discards all held beats.
REQ-012 Port out_valid, output, 1: output entry holds a valid beat.
REQ-013 Port out_ready, input, 1: downstream stage can take the beat.
REQ-014 Port out_ctrl, output, CTRL_W: control bits of the output entry.
REQ-015 Port out_data, output, DATA_W: payload of the output entry.
REQ-016 Port occ, output, 2: number of valid entries held, 0 to 2.
REQ-017 Port bubble_cnt, output, CNT_W: saturating count of cycles in which out_valid was 0.

Function
REQ-018 The stage SHALL hold two entries, MAIN (drives the outputs) and SKID, each with a valid bit, and SHALL preserve beat order.
REQ-019 Push = in_valid & in_ready; pop = out_valid & out_ready & ~stall.
REQ-020 in_ready SHALL be a registered signal equal to ~SKID.valid.
REQ-021 Latency: a beat pushed into an empty stage SHALL appear on out_* with out_valid=1 in the next cycle.
REQ-022 MAIN empty, or MAIN valid and popped, with push: the beat loads MAIN.
REQ-023 MAIN valid and not popped, with push: the beat loads SKID; in_ready=0 from the next cycle.
REQ-024 Both valid, with pop: SKID moves to MAIN and SKID is cleared; in_ready=1 from the next cycle.
REQ-025 MAIN valid, pop, no push, SKID empty: MAIN.valid=0.
REQ-026 stall=1: MAIN SHALL hold value and valid; a push is still accepted into whichever entry is free.
REQ-027 flush=1: both valid bits SHALL clear next cycle, and any same-cycle push SHALL be dropped.
REQ-028 flush SHALL take priority over stall, push and pop.
REQ-029 out_ctrl SHALL be forced to all-zero whenever out_valid=0, so a bubble behaves as a nop.
REQ-030 out_data SHALL hold its last value when out_valid=0.
REQ-031 occ = MAIN.valid + SKID.valid; occ SHALL never exceed 2.
REQ-032 bubble_cnt SHALL increment each cycle out_valid=0, SHALL saturate at 2^CNT_W-1, and SHALL not wrap.

Reset
REQ-033 While rst=1, asynchronously: both valid bits=0, out_ctrl=0, out_data=0, SKID contents=0, occ=0, bubble_cnt=0, in_ready=1.
REQ-034 A reset asserted mid-operation SHALL discard all held beats with no partial output.
REQ-035 The first push SHALL be accepted in the first clock edge after rst deasserts.

Verification
REQ-036 Reset release, out_ready=1, push A=0x11 then B=0x22 on consecutive cycles -> out_data 0x11 then 0x22 on the following cycles, out_valid=1, occ=1, in_ready stays 1.
REQ-037 out_ready=0, push A then B -> occ=2 and in_ready=0 on the next cycle; a third beat C is not accepted; raise out_ready -> out A, then B, then C (after it is re-presented), in order, none lost.
REQ-038 occ=2, stall=1 with out_ready=1 for 3 cycles -> out_data constant and occ=2; after stall drops, A then B pop.
REQ-039 occ=2 and flush=1 with in_valid=1 carrying C -> next cycle out_valid=0, out_ctrl=0, occ=0; C never appears on out_*.
REQ-040 CNT_W=4, idle for 20 cycles after reset -> bubble_cnt=15 and held at 15.
REQ-041 rst pulsed asynchronously between clock edges while occ=2 -> outputs reach their reset values before the next edge; the stage resumes normally afterwards.
